rom_lookup_ctrl: RTL and testbench

Request-side controller for the four table ROMs (`cust_rom0`..`cust_rom3`). It accepts lookup requests over a valid/ready handshake and drives the selected ROM's chip-select and shared address. It tracks the ROMs' fixed two-edge read latency in a shadow pipeline and captures the returned word into a response FIFO. Credit-based issue guarantees no ROM result is ever dropped under downstream backpressure, because the ROMs themselves cannot stall.

---
 rtl/rom_lookup_ctrl.sv | 137 +++++++++++++
 tb/tb_rom_lookup_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_lookup_ctrl.sv
// Request-side controller for four fixed-latency table ROMs with a credit-protected response FIFO.
// Optional tag pass-through is enabled by defining LOOKUP_TAG_EN.
module rom_lookup_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_sel,
  input  logic [ADDR_WIDTH-1:0] req_addr,
`ifdef LOOKUP_TAG_EN
  input  logic [3:0]            req_tag,
  output logic [3:0]            rsp_tag,
`endif
  output logic [3:0]            rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout0,
  input  logic [DATA_WIDTH-1:0] rom_dout1,
  input  logic [DATA_WIDTH-1:0] rom_dout2,
  input  logic [DATA_WIDTH-1:0] rom_dout3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_sel
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                  fire;
  logic                  pop;
  logic                  wr_en;
  logic                  s1_valid;
  logic                  s2_valid;
  logic [1:0]            s1_sel;
  logic [1:0]            s2_sel;
  logic [1:0]            inflight;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        slots_needed;
  logic [DATA_WIDTH-1:0] rom_word;
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [1:0]            sel_mem  [FIFO_DEPTH];

  // Chip-selects are masked by reset so no ROM is strobed while the controller is held.
  assign fire      = req_valid & req_ready & ~rst0;
  assign pop       = rsp_valid & rsp_ready;
  assign wr_en     = s2_valid;
  assign rsp_valid = (count != '0);
  assign rom_addr  = req_addr;

  // Every read in the shadow pipeline already owns a FIFO slot, so issue only when one is free.
  assign inflight     = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign slots_needed = {1'b0, count} + {{(CNT_W-1){1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign req_ready    = slots_needed < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    rom_cs          = '0;
    rom_cs[req_sel] = fire;
  end

  always_comb begin
    rom_word = rom_dout0;
    case (s2_sel)
      2'd0: rom_word = rom_dout0;
      2'd1: rom_word = rom_dout1;
      2'd2: rom_word = rom_dout2;
      2'd3: rom_word = rom_dout3;
      default: rom_word = rom_dout0;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s2_valid <= 1'b0;
      s2_sel   <= '0;
    end else begin
      s1_valid <= fire;
      s1_sel   <= req_sel;
      s2_valid <= s1_valid;
      s2_sel   <= s1_sel;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      count <= count + CNT_W'(1);
      else if (!wr_en && pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; the head is masked by rsp_valid below.
  always_ff @(posedge clk0) begin
    if (wr_en) begin
      data_mem[wr_ptr] <= rom_word;
      sel_mem[wr_ptr]  <= s2_sel;
    end
  end

  assign rsp_data = rsp_valid ? data_mem[rd_ptr] : '0;
  assign rsp_sel  = rsp_valid ? sel_mem[rd_ptr]  : '0;

`ifdef LOOKUP_TAG_EN
  logic [3:0] s1_tag;
  logic [3:0] s2_tag;
  logic [3:0] tag_mem [FIFO_DEPTH];

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      s1_tag <= '0;
      s2_tag <= '0;
    end else begin
      s1_tag <= req_tag;
      s2_tag <= s1_tag;
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_en) tag_mem[wr_ptr] <= s2_tag;
  end

  assign rsp_tag = rsp_valid ? tag_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_rom_lookup_ctrl.sv
// Directed bench for rom_lookup_ctrl with behavioural two-edge-latency ROM models.
// Tag checks are compiled in when LOOKUP_TAG_EN is defined.
module tb_rom_lookup_ctrl;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic [7:0]  req_addr;
  logic [3:0]  rom_cs;
  logic [7:0]  rom_addr;
  logic [31:0] rom_dout [4];
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_sel;
  logic [3:0]  cur_tag;
`ifdef LOOKUP_TAG_EN
  logic [3:0]  req_tag;
  logic [3:0]  rsp_tag;
  assign req_tag = cur_tag;
`endif

  typedef struct {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [3:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cyc[$];
  int   check_count = 0;
  int   fail_count  = 0;
  int   rsp_seen    = 0;
  int   cyc         = 0;

  rom_lookup_ctrl dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_addr  (req_addr),
`ifdef LOOKUP_TAG_EN
    .req_tag   (req_tag),
    .rsp_tag   (rsp_tag),
`endif
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_dout0 (rom_dout[0]),
    .rom_dout1 (rom_dout[1]),
    .rom_dout2 (rom_dout[2]),
    .rom_dout3 (rom_dout[3]),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_sel   (rsp_sel)
  );

  always #5 clk0 = ~clk0;

  function automatic logic [31:0] table_word(input logic [1:0] sel, input logic [7:0] addr);
    return {6'h30, sel, addr ^ 8'hA5, addr, 8'h3C + {sel, 6'h00}};
  endfunction

  // ROM model: address registered at the chip-select edge, word appears one edge later.
  logic [3:0] rom_cs_q = '0;
  logic [7:0] rom_addr_q [4];
  initial begin
    for (int i = 0; i < 4; i++) rom_dout[i] = 32'hDEAD_0000 + 32'(i);
  end
  always @(posedge clk0) begin
    for (int i = 0; i < 4; i++) begin
      if (rom_cs_q[i]) rom_dout[i] <= table_word(2'(i), rom_addr_q[i]);
      rom_cs_q[i]   <= rom_cs[i];
      rom_addr_q[i] <= rom_addr;
    end
  end

  always @(posedge clk0) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic [7:0] addr, input logic [3:0] tag);
    req_valid = valid;
    req_sel   = sel;
    req_addr  = addr;
    cur_tag   = tag;
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [7:0] addr, input logic [3:0] tag, input logic expect_ready);
    exp_t e;
    applyStimulus(1'b1, sel, addr, tag);
    #1;
    checkOutput("req_ready", 32'(req_ready), 32'(expect_ready));
    if (expect_ready) begin
      e.sel  = sel;
      e.addr = addr;
      e.tag  = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_seen < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("wait_rsp", 32'(rsp_seen), 32'(target));
  endtask

  // Response monitor: every pop must match the oldest outstanding expectation.
  always @(negedge clk0) begin
    if (!rst0 && rsp_valid && rsp_ready) begin
      exp_t e;
      rsp_cyc.push_back(cyc);
      rsp_seen++;
      checkOutput("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("rsp_data", rsp_data, table_word(e.sel, e.addr));
        checkOutput("rsp_sel", 32'(rsp_sel), 32'(e.sel));
`ifdef LOOKUP_TAG_EN
        checkOutput("rsp_tag", 32'(rsp_tag), 32'(e.tag));
`endif
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst0      = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    repeat (2) tick();

    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rom_cs", 32'(rom_cs), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_sel", 32'(rsp_sel), 32'd0);
    req_valid = 1'b1;
    #1;
    checkOutput("rst_cs_masked", 32'(rom_cs), 32'd0);
    req_valid = 1'b0;
    rst0 = 1'b0;
    tick();

    // Single lookup: sel 2, addr 0x15, two-cycle latency.
    issue(2'd2, 8'h15, 4'h0, 1'b1);
    checkOutput("single_cs", 32'(rom_cs), 32'b0100);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    #1;
    checkOutput("single_cs_after", 32'(rom_cs), 32'd0);
    checkOutput("single_lat1", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("single_lat2", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("single_lat3", 32'(rsp_valid), 32'd1);
    checkOutput("single_data", rsp_data, table_word(2'd2, 8'h15));
    checkOutput("single_sel", 32'(rsp_sel), 32'd2);
    wait_rsp(1, 5);

    // Back-to-back: eight requests cycling through all tables.
    base = rsp_seen;
    for (int i = 0; i < 8; i++) begin
      issue(2'(i), 8'(i), 4'h0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    wait_rsp(base + 8, 20);
    checkOutput("b2b_consecutive", 32'(rsp_cyc[rsp_seen-1] - rsp_cyc[rsp_seen-8]), 32'd7);

    // Backpressure: only FIFO_DEPTH accepts while the consumer stalls.
    base = rsp_seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(2'(i), 8'(64 + i), 4'h0, i < 4);
      tick();
    end
    checkOutput("bp_full_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    issue(2'd0, 8'h50, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    wait_rsp(base + 5, 20);

    // Idle ROM holding a stale word must not produce extra responses.
    base = rsp_seen;
    issue(2'd1, 8'h03, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    repeat (6) tick();
    checkOutput("stale_count", 32'(rsp_seen), 32'(base + 1));
    checkOutput("stale_valid", 32'(rsp_valid), 32'd0);

    // Reset with two reads in flight discards both.
    applyStimulus(1'b1, 2'd0, 8'h21, 4'h0);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h22, 4'h0);
    tick();
    rst0 = 1'b1;
    #1;
    checkOutput("midrst_cs", 32'(rom_cs), 32'd0);
    checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst0 = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    base = rsp_seen;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("postrst_valid", 32'(rsp_valid), 32'd0);
    end
    issue(2'd3, 8'h77, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    wait_rsp(base + 1, 10);
    repeat (3) tick();
    checkOutput("postrst_only_one", 32'(rsp_seen), 32'(base + 1));

`ifdef LOOKUP_TAG_EN
    // Tags must come back aligned with their data.
    base = rsp_seen;
    issue(2'd0, 8'h60, 4'hA, 1'b1);
    tick();
    issue(2'd1, 8'h61, 4'h5, 1'b1);
    tick();
    issue(2'd2, 8'h62, 4'hF, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'h0);
    wait_rsp(base + 3, 10);
`endif

    checkOutput("leftover_expect", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
